store_commit_buffer: RTL and testbench

STORE_COMMIT_BUFFER -- requirements
Module: store_commit_buffer

---
 rtl/store_commit_buffer.sv | 150 +++++++++++++++
 tb/tb_store_commit_buffer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_commit_buffer.sv
// Store commit buffer: holds executed stores until they retire, drains retired
// stores to data memory in order, and forwards buffered data to loads.
// Storage is one circular array split by three pointers:
//   head .. cptr-1  committed (waiting to drain)
//   cptr .. tail-1  uncommitted (may still be squashed)
module store_commit_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fin_valid,
    input  logic [31:0] fin_addr,
    input  logic [31:0] fin_data,
    output logic        fin_ready,
    input  logic        commit,
    input  logic        flush,
    output logic        mem_wvalid,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    input  logic        mem_wready,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic [31:0] ld_data,
    output logic [4:0]  count,
    output logic        err_commit
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] cptr_q, cptr_d;
    logic [PW-1:0] tail_q, tail_d;
    logic          err_q, err_d;

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic [PW-1:0] occ_s;
    logic [PW-1:0] ncom_s;
    logic [PW-1:0] nunc_s;
    logic          accept_s;
    logic          commit_ok_s;
    logic          commit_err_s;
    logic          drain_s;
    logic [IW-1:0] fwd_idx_s;
    logic          fwd_hit_s;
    logic [31:0]   fwd_data_s;

    assign occ_s  = tail_q - head_q;
    assign ncom_s = cptr_q - head_q;
    assign nunc_s = tail_q - cptr_q;

    // Space is judged on registered occupancy only; a drain this cycle does
    // not make room for an accept this cycle.
    assign fin_ready = (occ_s < DEPTH_P) && !flush;
    assign accept_s  = fin_valid && fin_ready;

    // Commit only sees entries present at the start of the cycle, so a store
    // accepted this cycle can never be covered by this cycle's commit.
    assign commit_ok_s  = commit && (nunc_s != {PW{1'b0}});
    assign commit_err_s = commit && (nunc_s == {PW{1'b0}});

    // Write request is held off while reset is asserted so a pending write is
    // dropped instead of being handshaken on the reset edge.
    assign mem_wvalid = rst && (ncom_s != {PW{1'b0}});
    assign mem_waddr  = addr_q[head_q[IW-1:0]];
    assign mem_wdata  = data_q[head_q[IW-1:0]];
    assign drain_s    = mem_wvalid && mem_wready;

    assign count      = 5'(occ_s);
    assign err_commit = err_q;
    assign ld_hit     = fwd_hit_s;
    assign ld_data    = fwd_data_s;

    // Next-state pointers: accept, commit and drain all apply together; a
    // flush pulls tail back to the post-commit cptr, squashing the rest.
    always_comb begin
        head_d = head_q;
        cptr_d = cptr_q;
        tail_d = tail_q;
        err_d  = err_q;
        if (drain_s) begin
            head_d = head_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            head_d = head_q;
        end
        if (commit_ok_s) begin
            cptr_d = cptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            cptr_d = cptr_q;
        end
        if (commit_err_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
        if (flush) begin
            tail_d = cptr_d;
        end else if (accept_s) begin
            tail_d = tail_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            tail_d = tail_q;
        end
    end

    // Pointer and sticky error registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q <= {PW{1'b0}};
            cptr_q <= {PW{1'b0}};
            tail_q <= {PW{1'b0}};
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            cptr_q <= cptr_d;
            tail_q <= tail_d;
            err_q  <= err_d;
        end
    end

    // Entry storage; contents are only meaningful inside head..tail-1
    always_ff @(posedge clk) begin
        if (accept_s) begin
            addr_q[tail_q[IW-1:0]] <= fin_addr;
            data_q[tail_q[IW-1:0]] <= fin_data;
        end
    end

    // Forwarding: walk occupied entries oldest to youngest so the youngest
    // word-address match is the one left standing.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = 32'h0000_0000;
        fwd_idx_s  = {IW{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx_s = head_q[IW-1:0] + IW'(k);
            if ((PW'(k) < occ_s) && (addr_q[fwd_idx_s][31:2] == ld_addr[31:2])) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = data_q[fwd_idx_s];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer: directed scenarios followed by
// randomized traffic, all compared every cycle against a queue-based model.
module tb_store_commit_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        fin_valid;
    logic [31:0] fin_addr;
    logic [31:0] fin_data;
    logic        fin_ready;
    logic        commit;
    logic        flush;
    logic        mem_wvalid;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wready;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic [4:0]  count;
    logic        err_commit;

    store_commit_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .fin_valid  (fin_valid),
        .fin_addr   (fin_addr),
        .fin_data   (fin_data),
        .fin_ready  (fin_ready),
        .commit     (commit),
        .flush      (flush),
        .mem_wvalid (mem_wvalid),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wready (mem_wready),
        .ld_addr    (ld_addr),
        .ld_hit     (ld_hit),
        .ld_data    (ld_data),
        .count      (count),
        .err_commit (err_commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    // Reference model: queue of buffered stores in age order; the first
    // m_ncom of them are committed.
    ent_t m_q[$];
    int   m_ncom;
    bit   m_err;
    bit   m_known;

    int n_cmp;
    int n_bad;

    // Memory write log (model side and DUT side) for in-order checking
    logic [63:0] exp_wr[$];
    logic [63:0] got_wr[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check outputs, then advance model on posedge
    task automatic cyc(input bit r, input bit fv, input logic [31:0] fa, input logic [31:0] fd,
                       input bit cm, input bit fl, input bit wr, input logic [31:0] la);
        bit          e_ready;
        bit          e_wvalid;
        bit          e_hit;
        logic [31:0] e_ldd;
        int          unc;
        int          new_ncom;
        @(negedge clk);
        rst        = r;
        fin_valid  = fv;
        fin_addr   = fa;
        fin_data   = fd;
        commit     = cm;
        flush      = fl;
        mem_wready = wr;
        ld_addr    = la;
        #1;
        e_ready  = (m_q.size() < DEPTH) && !fl;
        e_wvalid = r && (m_ncom > 0);
        e_hit    = 1'b0;
        e_ldd    = 32'h0;
        for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (!e_hit && (m_q[i].a[31:2] == la[31:2])) begin
                e_hit = 1'b1;
                e_ldd = m_q[i].d;
            end
        end
        if (m_known) begin
            check_eq("count", 32'(count), 32'(m_q.size()));
            check_eq("fin_ready", 32'(fin_ready), 32'(e_ready));
            check_eq("mem_wvalid", 32'(mem_wvalid), 32'(e_wvalid));
            check_eq("err_commit", 32'(err_commit), 32'(m_err));
            check_eq("ld_hit", 32'(ld_hit), 32'(e_hit));
            check_eq("ld_data", ld_data, e_ldd);
            if (m_ncom > 0) begin
                check_eq("mem_waddr", mem_waddr, m_q[0].a);
                check_eq("mem_wdata", mem_wdata, m_q[0].d);
            end
        end
        if (mem_wvalid && mem_wready) got_wr.push_back({mem_waddr, mem_wdata});
        @(posedge clk);
        if (!r) begin
            m_q.delete();
            m_ncom  = 0;
            m_err   = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            unc      = m_q.size() - m_ncom;
            new_ncom = m_ncom;
            if (cm) begin
                if (unc > 0) new_ncom = m_ncom + 1;
                else         m_err = 1'b1;
            end
            if (fl) begin
                while (m_q.size() > new_ncom) void'(m_q.pop_back());
            end
            if (e_wvalid && wr) begin
                exp_wr.push_back({m_q[0].a, m_q[0].d});
                void'(m_q.pop_front());
                new_ncom = new_ncom - 1;
            end
            m_ncom = new_ncom;
            if (fv && e_ready) m_q.push_back('{a: fa, d: fd});
        end
    endtask

    task automatic idle(input bit wr);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, wr, 32'h0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input bit cm);
        cyc(1'b1, 1'b1, a, d, cm, 1'b0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        int p_fv;
        int p_cm;
        n_cmp   = 0;
        n_bad   = 0;
        m_ncom  = 0;
        m_err   = 1'b0;
        m_known = 1'b0;
        rst = 1'b0; fin_valid = 1'b0; fin_addr = 32'h0; fin_data = 32'h0;
        commit = 1'b0; flush = 1'b0; mem_wready = 1'b0; ld_addr = 32'h0;

        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        idle(1'b0);

        // Single store, commit, drain
        store(32'h10, 32'hAA, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h10);
        idle(1'b1);
        idle(1'b1);

        // Overfill with no commits, then retire everything
        for (int i = 0; i < 6; i++) store(32'h40 + 32'(i * 4), 32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h48);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Youngest-match forwarding, then retire both
        store(32'h20, 32'h1, 1'b0);
        store(32'h20, 32'h2, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h22);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h22);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h22);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h22);

        // Flush keeps only the committed store; stray commit sets error
        store(32'h30, 32'h31, 1'b0);
        store(32'h34, 32'h32, 1'b0);
        store(32'h38, 32'h33, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h34);
        cyc(1'b1, 1'b1, 32'h3C, 32'h34, 1'b0, 1'b1, 1'b0, 32'h34);
        idle(1'b1);
        idle(1'b1);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(1'b0);

        // Reset while committed writes are pending and memory is ready
        store(32'h50, 32'h51, 1'b0);
        store(32'h54, 32'h52, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h50);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h50);
        idle(1'b1);

        // Steady stream with memory ready alternating across pointer wrap
        for (int i = 0; i < 30; i++)
            cyc(1'b1, (i < 10), 32'h80 + 32'(i * 4), 32'h900 + 32'(i), (i > 0 && i < 16), 1'b0,
                (i % 2) == 0, 32'h80 + 32'((i % 10) * 4));

        // Randomized traffic with changing bias
        for (int i = 0; i < 4000; i++) begin
            if ((i % 500) == 0) begin
                p_fv = ((i / 500) % 2 == 0) ? 80 : 30;
                p_cm = ((i / 500) % 3 == 0) ? 20 : 60;
            end
            cyc(($urandom_range(0, 299) != 0),
                ($urandom_range(0, 99) < p_fv), rnd_addr(), $urandom(),
                ($urandom_range(0, 99) < p_cm),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 1) == 1),
                rnd_addr());
        end
        idle(1'b0);

        check_eq("write_count", 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            if (got_wr[i] !== exp_wr[i]) begin
                check_eq("write_order_addr", got_wr[i][63:32], exp_wr[i][63:32]);
                check_eq("write_order_data", got_wr[i][31:0], exp_wr[i][31:0]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
